// File: rtl/uart_mon_pkg.sv
// uart_mon_pkg: shared types and constants for the UART receive monitor.
package uart_mon_pkg;
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_rx_state_e;
    localparam logic [7:0] UART_LF        = 8'h0A;
    localparam int         UART_DATA_BITS = 8;
endpackage

// File: rtl/uart_mon_fifo.sv
// uart_mon_fifo: synchronous FIFO with a registered head output.
module uart_mon_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    // dout is preloaded with whatever will be the head after this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (do_pop)
                dout <= (count == (AW+1)'(1)) ? din : mem[rd_ptr + 1'b1];
            else if (do_push && empty)
                dout <= din;
        end
    end
endmodule

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 UART receiver feeding a byte FIFO, with eol,
// framing-error and overflow reporting.
module uart_rx_monitor
    import uart_mon_pkg::*;
#(
    parameter int CLKS_PER_BIT = 32,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_i,
    output logic [7:0]                    m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          eol_o,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    input  logic                          clear_i
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    uart_rx_state_e              state;
    logic                        rx_meta, rx_sync, armed;
    logic [1:0]                  warm;
    logic [CW-1:0]               cnt;
    logic [2:0]                  bit_idx;
    logic [UART_DATA_BITS-1:0]   shreg;
    logic                        half_tick, bit_tick, push, pop, stop_err, full, empty;
    assign half_tick = cnt == CW'(CLKS_PER_BIT / 2 - 1);
    assign bit_tick  = cnt == CW'(CLKS_PER_BIT - 1);
    assign push      = state == ST_STOP && bit_tick && rx_sync;
    assign stop_err  = state == ST_STOP && bit_tick && !rx_sync;
    assign pop       = m_valid_o && m_ready_i;
    assign m_valid_o = !empty;
    // armed blocks a start until the line has been seen idle after reset,
    // so a frame in flight at reset release is never picked up mid-way
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            warm    <= '0;
            armed   <= 1'b0;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            warm    <= {warm[0], 1'b1};
            armed   <= armed | (warm[1] & rx_sync);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            cnt <= (state == ST_IDLE || (state == ST_START && half_tick) || bit_tick) ? '0 : cnt + 1'b1;
            case (state)
                ST_IDLE:      if (armed && !rx_sync) state <= ST_START;
                ST_START: begin
                    bit_idx <= '0;
                    if (half_tick) state <= rx_sync ? ST_IDLE : ST_DATA;
                end
                ST_DATA: if (bit_tick) begin
                    shreg   <= {rx_sync, shreg[UART_DATA_BITS-1:1]};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'(UART_DATA_BITS - 1)) state <= ST_STOP;
                end
                ST_STOP:      if (bit_tick) state <= rx_sync ? ST_IDLE : ST_WAIT_IDLE;
                ST_WAIT_IDLE: if (rx_sync) state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eol_o       <= 1'b0;
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            eol_o       <= push && (!full || pop) && shreg == UART_LF;
            frame_err_o <= stop_err | (frame_err_o & !clear_i);
            overflow_o  <= (push && full && !pop) | (overflow_o & !clear_i);
        end
    end
    uart_mon_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (shreg),
        .pop   (pop),
        .dout  (m_data_o),
        .full  (full),
        .empty (empty),
        .count (count_o)
    );
endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: vector table plus directed corner cases, with a
// scoreboard queue checked on every FIFO pop.
module tb_uart_rx_monitor;
    localparam int CPB = 32;
    localparam int DEPTH = 16;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_i = 1'b1;
    logic       m_ready_i = 1'b0;
    logic       clear_i = 1'b0;
    logic [7:0] m_data_o;
    logic       m_valid_o, eol_o, frame_err_o, overflow_o;
    logic [4:0] count_o;
    int         checks = 0;
    int         passed = 0;
    int         cyc = 0;
    int         eol_total = 0;
    int         start_cyc = 0;
    int         rise_cyc = -1;
    logic       prev_valid = 1'b0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] data;
        int         stop_low;
        logic       exp_eol;
        logic       exp_ferr;
    } vec_t;
    vec_t vecs [6];

    uart_rx_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .count_o     (count_o),
        .eol_o       (eol_o),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o),
        .clear_i     (clear_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // samples mid-low-phase, after the bench's negedge drives have settled
    always begin
        @(negedge clk);
        #2;
        if (eol_o) eol_total++;
        if (m_valid_o && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
        prev_valid = m_valid_o;
        if (rst_n && m_valid_o && m_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL sb_extra: got %0h required no byte", m_data_o);
            end else check("sb_data", {24'h0, m_data_o}, {24'h0, exp_q.pop_front()});
        end
    end

    task automatic send_frame(input logic [7:0] b, input int stop_low);
        rx_i = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (stop_low > 0) begin
            rx_i = 1'b0;
            repeat (stop_low * CPB) @(negedge clk);
        end
        rx_i = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic drain();
        m_ready_i = 1'b1;
        for (int i = 0; i < 400 && count_o != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("drain_count", {27'h0, count_o}, 32'h0);
        check("drain_sb_left", exp_q.size(), 32'h0);
        m_ready_i = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0;
        vecs[0] = '{8'h00, 0, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 0, 1'b0, 1'b0};
        vecs[2] = '{8'h81, 0, 1'b0, 1'b0};
        vecs[3] = '{8'h0A, 0, 1'b1, 1'b0};
        vecs[4] = '{8'hC3, 2, 1'b0, 1'b1};
        vecs[5] = '{8'h5A, 0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_valid", m_valid_o, 0);
        check("rst_data", m_data_o, 0);
        check("rst_count", count_o, 0);
        check("rst_flags", {eol_o, frame_err_o, overflow_o}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // single byte, latency from start-bit drive to m_valid_o
        exp_q.push_back(8'h55);
        send_frame(8'h55, 0);
        check("lat_valid_rise", rise_cyc - start_cyc, CPB / 2 + 9 * CPB + 3);
        check("b55_data", m_data_o, 8'h55);
        check("b55_count", count_o, 1);
        check("b55_flags", {frame_err_o, overflow_o}, 0);
        drain();

        // "OK\n" back to back, consumer stalled
        e0 = eol_total;
        foreach (exp_q[i]) ;
        exp_q.push_back(8'h4F);
        exp_q.push_back(8'h4B);
        exp_q.push_back(8'h0A);
        send_frame(8'h4F, 0);
        send_frame(8'h4B, 0);
        check("ok_no_eol_yet", eol_total - e0, 0);
        send_frame(8'h0A, 0);
        check("ok_count", count_o, 3);
        check("ok_eol_once", eol_total - e0, 1);
        repeat (5) @(negedge clk);
        check("ok_head_hold", m_data_o, 8'h4F);
        drain();

        // table of single frames with the consumer always ready
        m_ready_i = 1'b1;
        foreach (vecs[i]) begin
            pulse_clear();
            e0 = eol_total;
            if (vecs[i].stop_low == 0) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_low);
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d_eol", i), eol_total - e0, vecs[i].exp_eol);
            check($sformatf("vec%0d_ferr", i), frame_err_o, vecs[i].exp_ferr);
        end
        check("vec_sb_left", exp_q.size(), 0);
        m_ready_i = 1'b0;
        pulse_clear();

        // short low glitch is rejected in START
        rx_i = 1'b0;
        repeat (10) @(negedge clk);
        rx_i = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_count", count_o, 0);
        check("glitch_flags", {m_valid_o, frame_err_o, overflow_o}, 0);

        // break: long low stop, then a good byte, then clear
        m_ready_i = 1'b1;
        send_frame(8'hA5, 20);
        check("brk_ferr", frame_err_o, 1);
        check("brk_count", count_o, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 0);
        repeat (4) @(negedge clk);
        check("brk_sb_left", exp_q.size(), 0);
        check("brk_ferr_sticky", frame_err_o, 1);
        pulse_clear();
        check("brk_ferr_clear", frame_err_o, 0);
        m_ready_i = 1'b0;

        // overflow: 17 bytes into 16 entries
        e0 = eol_total;
        for (int i = 0; i < 17; i++) begin
            if (i < DEPTH) exp_q.push_back(8'(i));
            send_frame(8'(i), 0);
        end
        check("ovf_count", count_o, DEPTH);
        check("ovf_flag", overflow_o, 1);
        check("ovf_eol", eol_total - e0, 1);
        drain();
        check("ovf_sticky", overflow_o, 1);
        pulse_clear();
        check("ovf_clear", overflow_o, 0);

        // reset during bit 4 with state and flags set beforehand
        send_frame(8'h77, 0);
        send_frame(8'h12, 1);
        check("pre_rst_state", {m_valid_o, frame_err_o}, 2'b11);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_i = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        rx_i = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", m_valid_o, 0);
        check("mid_rst_data", m_data_o, 0);
        check("mid_rst_count", count_o, 0);
        check("mid_rst_flags", {eol_o, frame_err_o, overflow_o}, 0);
        rst_n = 1'b1;
        repeat (CPB / 2 - 1 + 3 * CPB) @(negedge clk);
        rx_i = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("post_rst_count", count_o, 0);
        check("post_rst_flags", {m_valid_o, frame_err_o}, 0);
        exp_q.push_back(8'h96);
        send_frame(8'h96, 0);
        check("post_rst_rx", m_data_o, 8'h96);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_monitor.md
# uart_rx_monitor

Synthesizable 8N1 UART receiver that consumes the `uart_tx` line driven by `pulpino_top` and buffers the received bytes for the bench or an FPGA debug path. It deserializes frames at a fixed clocks-per-bit ratio and pushes bytes into a small FIFO with a valid/ready output. It also flags line-feed characters, framing errors and overflow, so the surrounding environment can log core output and detect end-of-test messages without a behavioural UART model.

## Interface
- `CLKS_PER_BIT`, default 32: clock cycles per UART bit (100 MHz / 3.125 Mbaud); must be ≥ 4.
- `FIFO_DEPTH`, default 16: byte FIFO entries; must be a power of two, ≥ 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx_i`  in  1  serial line from the DUT; asynchronous; idles high.
- `m_data_o`  out  8  byte at the FIFO head.
- `m_valid_o`  out  1  FIFO non-empty.
- `m_ready_i`  in  1  consumer accepts the head byte when `m_valid_o` is high.
- `count_o`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `eol_o`  out  1  one-cycle pulse when byte 8'h0A is written into the FIFO.
- `frame_err_o`  out  1  sticky flag: a stop bit was sampled low.
- `overflow_o`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `clear_i`  in  1  synchronous clear of both sticky flags.

## Operation
- `rx_i` passes through a 2-flop synchronizer; both flops reset to 1.
- The receiver is a state machine with states IDLE, START, DATA, STOP and WAIT_IDLE. A bit-period counter and a 3-bit bit index support it.
- IDLE:
  - Synchronized rx = 0 → go to START and clear the counter.
- START:
  - After CLKS_PER_BIT/2 cycles, sample the line.
  - Sample 0 → go to DATA with bit index 0.
  - Sample 1 → treat as a glitch and return to IDLE. No flag is set.
- DATA:
  - Sample every CLKS_PER_BIT cycles and shift LSB first.
  - After bit 7, go to STOP.
- STOP:
  - Sample after CLKS_PER_BIT cycles.
  - Sample 1 → push the byte and return to IDLE.
  - Sample 0 → discard the byte, set `frame_err_o`, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until the synchronized rx is 1, then go to IDLE. A break condition produces exactly one error.
- FIFO rules:
  - Pop happens when `m_valid_o && m_ready_i`.
  - Push into a full FIFO with no simultaneous pop → byte dropped, `overflow_o` set, `eol_o` not pulsed.
  - Push into a full FIFO with a simultaneous pop → push accepted; count unchanged.
  - Push into an empty FIFO → `m_valid_o` rises the next cycle. There is no bypass.
  - Pointers wrap modulo FIFO_DEPTH. `count_o` never exceeds FIFO_DEPTH.
- `clear_i` together with a new error in the same cycle → the flag stays set (set wins).
- Reset mid-frame → the partial byte is lost. The FSM returns to IDLE, waits for a fresh falling edge, and does not resynchronize to the frame in flight.

## Timing
- Reset values:
  - `m_valid_o` = 0, `m_data_o` = 0, `count_o` = 0.
  - `eol_o` = 0, `frame_err_o` = 0, `overflow_o` = 0.
  - FSM in IDLE.
- Synchronizer latency: 2 cycles from `rx_i` to the FSM.
- Stop-bit sample point: cycle (CLKS_PER_BIT/2 + 9·CLKS_PER_BIT) after the FSM sees the start edge. The write occurs in that cycle.
- `m_valid_o`, `count_o` and `eol_o` update on the edge following the write.
- `m_data_o` is registered and reflects the head entry; it is stable while `m_valid_o` is high and `m_ready_i` is low.
- Back-to-back frames with a 1-bit stop are received without loss.
- Baud tolerance: at least ±3 % at CLKS_PER_BIT = 32.

## Structure
- Package `uart_mon_pkg` holds:
  - the FSM state enum `uart_rx_state_e`,
  - `UART_LF` = 8'h0A,
  - `UART_DATA_BITS` = 8.
- Sub-module `uart_mon_fifo` is a synchronous FIFO parameterized by width and depth, with `clk`/`rst_n`, push/pop, full/empty and count. The top level holds the synchronizer, FSM, error flags and eol logic.

## Test plan
- Reset, then send 8'h55 with CLKS_PER_BIT = 32 → `m_data_o` = 8'h55 and `m_valid_o` = 1 on the cycle after the stop sample; `count_o` = 1; no flags set.
- Send "OK\n" back-to-back with `m_ready_i` = 0 → `count_o` = 3; `eol_o` pulses exactly once, on the 8'h0A write; draining yields 8'h4F, 8'h4B, 8'h0A in order.
- Drive a 10-cycle low glitch on `rx_i` → FSM returns to IDLE; no byte pushed; no flags set.
- Send 8'hA5 with a stop bit held low for 20 bit times → byte discarded; `frame_err_o` = 1. The next valid 8'h3C is received correctly. Pulse `clear_i` → `frame_err_o` = 0.
- With `m_ready_i` = 0, send 17 bytes (0x00..0x10) into a 16-entry FIFO → `count_o` = 16 and `overflow_o` = 1; draining yields 0x00..0x0F.
- Assert `rst_n` low during bit 4 of a frame → all outputs return to their reset values. The remainder of the frame produces no push; the next full frame is received.
